// File: rtl/el2_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : el2_ifu_pkg
// Description : Shared types and constants for the IFU ICCM arbiter slice.
//               - ICCM_ADDR_W     : ICCM halfword/doubleword address width
//               - WR_SIZE_DW      : write size used for full-doubleword writes
//               - dma_buf_entry_t : one buffered DMA request
// Revision    : 1.0 - initial release
// ============================================================================
package el2_ifu_pkg;

    localparam int         ICCM_ADDR_W = 15;
    localparam logic [2:0] WR_SIZE_DW  = 3'b011;

    // The address is kept already converted to the ICCM address space
    // (byte address bits [15:1]); the rest of the byte address is not needed.
    typedef struct packed {
        logic [ICCM_ADDR_W-1:0] addr;
        logic [2:0]             sz;
        logic                   write;
        logic [63:0]            wdata;
        logic [2:0]             tag;
    } dma_buf_entry_t;

endpackage : el2_ifu_pkg
`default_nettype wire

// File: rtl/el2_iccm_dma_buf.sv
`default_nettype none
// ============================================================================
// Module      : el2_iccm_dma_buf
// Description : One-entry DMA request buffer for the ICCM arbiter.
//               Captures a request strobe only while empty; releases the
//               entry in the cycle the arbiter grants it.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_req         - request strobe
//               i_entry       - request payload to capture
//               i_pop         - buffered request granted this cycle
//               o_valid       - buffer holds a request
//               o_ready       - buffer empty (can accept a strobe)
//               o_entry       - buffered request payload
// Revision    : 1.0 - initial release
// ============================================================================
module el2_iccm_dma_buf
    import el2_ifu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           i_req,
    input  dma_buf_entry_t i_entry,
    input  logic           i_pop,
    output logic           o_valid,
    output logic           o_ready,
    output dma_buf_entry_t o_entry
);

    logic           r_valid;
    dma_buf_entry_t r_entry;
    logic           w_load;

    // A strobe that arrives while full is dropped; the requester must retry.
    assign w_load = i_req & ~r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_entry <= i_entry;
            end else if (i_pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_ready = ~r_valid;
    assign o_entry = r_entry;

endmodule : el2_iccm_dma_buf
`default_nettype wire

// File: rtl/el2_ifu_iccm_arb.sv
`default_nettype none
// ============================================================================
// Module      : el2_ifu_iccm_arb
// Description : Single-port ICCM access arbiter. Shares the ICCM SRAM port
//               between ECC correction write-back, buffered DMA requests and
//               IFU fetch. Priority: correction > forced DMA > fetch > DMA.
// Ports       : clock/reset                 - core clock, sync active-high rst
//               io_ifc_*/io_exu_flush_final - fetch request side
//               io_fetch_gnt                - fetch owns the port this cycle
//               io_dma_*                    - DMA request side
//               io_iccm_ready               - DMA buffer empty
//               io_iccm_dma_r*              - DMA read response
//               io_ecc_corr_*               - correction write-back
//               io_iccm_rw_addr/rden/wren/wr_data_raw/wr_size - SRAM controls
//               io_iccm_rd_data             - SRAM read data (1-cycle latency)
// Config      : EL2_ICCM_DMA_STARVE_EN - when defined, a buffered DMA request
//               that loses to fetch STARVE_MAX cycles in a row is forced
//               through. When undefined, DMA always beats fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module el2_ifu_iccm_arb
    import el2_ifu_pkg::*;
#(
    parameter int STARVE_MAX = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_ifc_fetch_req_bf,
    input  logic                   io_ifc_iccm_access_bf,
    input  logic [30:0]            io_ifc_fetch_addr_bf,
    input  logic                   io_exu_flush_final,
    output logic                   io_fetch_gnt,
    input  logic                   io_dma_iccm_req,
    input  logic [31:0]            io_dma_mem_addr,
    input  logic [2:0]             io_dma_mem_sz,
    input  logic                   io_dma_mem_write,
    input  logic [63:0]            io_dma_mem_wdata,
    input  logic [2:0]             io_dma_mem_tag,
    output logic                   io_iccm_ready,
    output logic                   io_iccm_dma_rvalid,
    output logic [2:0]             io_iccm_dma_rtag,
    output logic [63:0]            io_iccm_dma_rdata,
    input  logic                   io_ecc_corr_req,
    input  logic [ICCM_ADDR_W-1:0] io_ecc_corr_addr,
    input  logic [63:0]            io_ecc_corr_wdata,
    output logic                   io_ecc_corr_ack,
    output logic [ICCM_ADDR_W-1:0] io_iccm_rw_addr,
    output logic                   io_iccm_rden,
    output logic                   io_iccm_wren,
    output logic [63:0]            io_iccm_wr_data_raw,
    output logic [2:0]             io_iccm_wr_size,
    input  logic [63:0]            io_iccm_rd_data
);

    // ------------------------------------------------------------------
    // DMA buffer
    // ------------------------------------------------------------------
    dma_buf_entry_t w_dma_in;
    dma_buf_entry_t w_buf;
    logic           w_buf_valid;
    logic           w_buf_ready;

    assign w_dma_in.addr  = io_dma_mem_addr[15:1];
    assign w_dma_in.sz    = io_dma_mem_sz;
    assign w_dma_in.write = io_dma_mem_write;
    assign w_dma_in.wdata = io_dma_mem_wdata;
    assign w_dma_in.tag   = io_dma_mem_tag;

    // Address bits outside the ICCM window are intentionally ignored.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{io_ifc_fetch_addr_bf[30:15],
                                  io_dma_mem_addr[31:16],
                                  io_dma_mem_addr[0]};

    logic w_dma_gnt;

    el2_iccm_dma_buf u_dma_buf (
        .clk     (clock),
        .rst     (reset),
        .i_req   (io_dma_iccm_req),
        .i_entry (w_dma_in),
        .i_pop   (w_dma_gnt),
        .o_valid (w_buf_valid),
        .o_ready (w_buf_ready),
        .o_entry (w_buf)
    );

    assign io_iccm_ready = w_buf_ready;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic w_fetch_elig;
    logic w_corr_gnt;
    logic w_fetch_gnt;
    logic w_dma_first;   // buffered DMA outranks fetch this cycle

    assign w_fetch_elig = io_ifc_fetch_req_bf & io_ifc_iccm_access_bf
                        & ~io_exu_flush_final;

`ifdef EL2_ICCM_DMA_STARVE_EN
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;

    // Counts consecutive fetch wins over a waiting DMA request. A cycle lost
    // to correction holds the count, so a forced DMA goes right after it.
    // Fetch cannot win once the count reaches the limit, so no wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!w_buf_valid || w_dma_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (w_fetch_gnt) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign w_dma_first = (r_starve_cnt == c_starve_max);
`else
    localparam int c_unused_starve_max = STARVE_MAX;

    assign w_dma_first = 1'b1;
`endif

    assign w_corr_gnt  = io_ecc_corr_req;
    assign w_dma_gnt   = ~w_corr_gnt & w_buf_valid & (w_dma_first | ~w_fetch_elig);
    assign w_fetch_gnt = ~w_corr_gnt & w_fetch_elig & ~(w_buf_valid & w_dma_first);

    assign io_ecc_corr_ack = w_corr_gnt;
    assign io_fetch_gnt    = w_fetch_gnt;

    // ------------------------------------------------------------------
    // SRAM port mux: only the granted requester drives; idle is all-zero.
    // ------------------------------------------------------------------
    always_comb begin
        io_iccm_rw_addr     = '0;
        io_iccm_rden        = 1'b0;
        io_iccm_wren        = 1'b0;
        io_iccm_wr_data_raw = '0;
        io_iccm_wr_size     = '0;
        if (w_corr_gnt) begin
            io_iccm_rw_addr     = io_ecc_corr_addr;
            io_iccm_wren        = 1'b1;
            io_iccm_wr_data_raw = io_ecc_corr_wdata;
            io_iccm_wr_size     = WR_SIZE_DW;
        end else if (w_dma_gnt) begin
            io_iccm_rw_addr = w_buf.addr;
            if (w_buf.write) begin
                io_iccm_wren        = 1'b1;
                io_iccm_wr_data_raw = w_buf.wdata;
                io_iccm_wr_size     = w_buf.sz;
            end else begin
                io_iccm_rden = 1'b1;
            end
        end else if (w_fetch_gnt) begin
            io_iccm_rw_addr = io_ifc_fetch_addr_bf[ICCM_ADDR_W-1:0];
            io_iccm_rden    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // DMA read response: SRAM data arrives one cycle after the grant.
    // ------------------------------------------------------------------
    logic       r_rvalid;
    logic [2:0] r_rtag;
    logic       w_dma_rd_gnt;
    logic       w_rvalid;

    assign w_dma_rd_gnt = w_dma_gnt & ~w_buf.write;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rtag   <= 3'd0;
        end else begin
            r_rvalid <= w_dma_rd_gnt;
            if (w_dma_rd_gnt) begin
                r_rtag <= w_buf.tag;
            end
        end
    end

    // Masking with reset drops a response whose grant preceded a reset, even
    // in the cycle the reset is first sampled.
    assign w_rvalid           = r_rvalid & ~reset;
    assign io_iccm_dma_rvalid = w_rvalid;
    assign io_iccm_dma_rtag   = r_rtag;
    assign io_iccm_dma_rdata  = w_rvalid ? io_iccm_rd_data : 64'd0;

endmodule : el2_ifu_iccm_arb
`default_nettype wire

// File: doc/el2_ifu_iccm_arb.md
# el2_ifu_iccm_arb

Single-port ICCM access arbiter for the EL2 IFU memory controller. Shares the ICCM SRAM port between three requesters: the ECC correction write-back, buffered DMA read/write requests, and IFU instruction fetch. Drives the ICCM address, enable and write controls, and returns DMA read responses with their tags. It sits between the fetch/DMA front ends and the ICCM macro, inside the IFU memory-control hierarchy.

## Interface
Parameters:
- STARVE_MAX, 7: consecutive cycles a buffered DMA request may lose to fetch before it is forced through (1..15).

Ports:
- clock  in  1  core clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- io_ifc_fetch_req_bf  in  1  fetch request.
- io_ifc_iccm_access_bf  in  1  fetch targets ICCM; fetch is eligible only when both this and io_ifc_fetch_req_bf are 1.
- io_ifc_fetch_addr_bf  in  31  fetch halfword address; ICCM address = bits [14:0].
- io_exu_flush_final  in  1  flush; fetch is ineligible in this cycle.
- io_fetch_gnt  out  1  fetch owns the ICCM port this cycle (combinational).
- io_dma_iccm_req  in  1  DMA request strobe; accepted only while io_iccm_ready=1.
- io_dma_mem_addr  in  32  DMA byte address; ICCM address = bits [15:1].
- io_dma_mem_sz  in  3  DMA size; forwarded on writes.
- io_dma_mem_write  in  1  1 = write, 0 = read.
- io_dma_mem_wdata  in  64  DMA write data.
- io_dma_mem_tag  in  3  DMA tag.
- io_iccm_ready  out  1  DMA buffer empty (registered).
- io_iccm_dma_rvalid  out  1  DMA read data valid.
- io_iccm_dma_rtag  out  3  tag of the returned read.
- io_iccm_dma_rdata  out  64  read data; equals io_iccm_rd_data while rvalid=1, 0 otherwise.
- io_ecc_corr_req  in  1  correction write request; held high until acknowledged.
- io_ecc_corr_addr  in  15  correction address.
- io_ecc_corr_wdata  in  64  corrected data.
- io_ecc_corr_ack  out  1  correction granted this cycle.
- io_iccm_rw_addr  out  15  SRAM address.
- io_iccm_rden  out  1  SRAM read enable.
- io_iccm_wren  out  1  SRAM write enable.
- io_iccm_wr_data_raw  out  64  pre-ECC write data.
- io_iccm_wr_size  out  3  write size.
- io_iccm_rd_data  in  64  SRAM read data, valid one cycle after rden.

## Operation
- One-entry DMA buffer (valid, addr, sz, write, wdata, tag). Loads when io_dma_iccm_req=1 and the buffer is empty. Clears in the cycle the buffered request is granted.
- io_iccm_ready = !buf_valid (registered). A strobe arriving while the buffer is full is ignored; requesters must hold or retry.
- Priority in each cycle: correction > DMA (when forced) > fetch > DMA.
  - Correction grant: io_ecc_corr_ack=1, io_iccm_wren=1, io_iccm_wr_size=3'b011.
  - DMA grant: write drives wren and io_iccm_wr_size=io_dma_mem_sz; read drives rden.
  - Fetch grant: rden.
- Starvation counter (4 bits):
  - Increments when buf_valid=1 and fetch wins.
  - Resets to 0 on a DMA grant or when the buffer is empty.
  - DMA is forced when count == STARVE_MAX.
- Unselected outputs: address and data are 0; rden and wren are 0.
- Response pipeline:
  - A DMA read granted in cycle N gives io_iccm_dma_rvalid=1 in N+1, with rtag registered from the buffer.
  - Fetch read data is not routed through this block.
- Only one grant per cycle. rden and wren are never both 1.
- No explicit FSM beyond buf_valid and the response-valid flop.

## Timing
- Values after reset:
  - Registers: buf_valid=0, count=0, rvalid=0, rtag=0.
  - Outputs: io_iccm_ready=1; all combinational outputs evaluate with no requests.
- Grants are combinational on the request cycle. DMA acceptance to earliest grant is 1 cycle; io_iccm_ready returns high the cycle after the grant.
- DMA read latency: request accepted in N, grant in N+1 at the earliest, rvalid in N+2.
- Correction plus a forced DMA in the same cycle: correction wins. count holds at STARVE_MAX and DMA goes next.
- Flush with fetch and DMA both pending: DMA is granted.
- Reset asserted mid-operation clears the buffer and any pending rvalid; no response is produced for that request.

## Configuration
- EL2_ICCM_DMA_STARVE_EN defined: starvation counter and forced-DMA behaviour as above.
- Not defined: no counter; fixed priority correction > DMA > fetch.

## Structure
- A shared package el2_ifu_pkg holds:
  - the DMA buffer entry struct (addr, sz, write, wdata, tag);
  - ICCM_ADDR_W=15;
  - the constant WR_SIZE_DW=3'b011.
- One natural sub-module, el2_iccm_dma_buf: the one-entry DMA buffer with its ready flag. Arbitration and the response pipeline stay in the top module.

## Test plan
- DMA read only: addr 0x0000_0010, tag 5 accepted in cycle 0. Expect a grant in cycle 1 with rw_addr=0x0008 and rden=1. In cycle 2 expect rvalid=1, rtag=5, and rdata=io_iccm_rd_data.
- Continuous fetch plus a pending DMA write (macro defined, STARVE_MAX=7): fetch wins for 7 cycles, then DMA is forced with wren=1. io_iccm_ready=1 the following cycle.
- Correction, DMA and fetch all requesting: cycle 0 gives io_ecc_corr_ack=1 and wr_size=3. Cycle 1 grants fetch (counter 1). Correction dropped.
- Strobe while the buffer is full: the second strobe (tag 2) is ignored. Only tag 1 is returned.
- Flush with fetch and DMA read pending: DMA is granted that cycle and io_fetch_gnt=0.
- Reset asserted in the cycle after a DMA read grant: rvalid stays 0 and io_iccm_ready=1 on the cycle after reset deasserts.
